// File: rtl/phase1_datapath_pkg.sv
// Shared widths and ALU opcodes for the phase-1 single-bus datapath.
//   WIDTH : datapath word width; Z is ZW = 2*WIDTH bits wide.
//   OP_*  : ALUControl encodings.
package phase1_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ZW    = 2 * WIDTH;
  localparam int unsigned OPW   = 5;
  localparam int unsigned SHW   = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_INC  = 5'b00000;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_NEG  = 5'b01100;
  localparam logic [OPW-1:0] OP_NOT  = 5'b01101;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;

endpackage

// File: rtl/phase1_datapath_if.sv
// Control strobes and observation outputs of the phase-1 datapath.
//   slave  : datapath side (strobes/Mdatain in, bus and register contents out)
//   master : controller/bench side
interface phase1_datapath_if;
  import phase1_pkg::*;

  logic              R0in, R1in, PCin, MARin, MDRin, IRin, Yin, Zin;
  logic              R0out, R1out, PCout, MDRout, ZLOout;
  logic              IncrementPC;
  logic              Read;
  logic [OPW-1:0]    ALUControl;
  logic [WIDTH-1:0]  Mdatain;

  logic [WIDTH-1:0]  big_boy_bus;
  logic [WIDTH-1:0]  R0_data_out, R1_data_out;
  logic [WIDTH-1:0]  MDR_data_in, MDR_data_out;
  logic [WIDTH-1:0]  Y_data_out;
  logic [ZW-1:0]     Z_data_out;

  modport slave (
    input  R0in, R1in, PCin, MARin, MDRin, IRin, Yin, Zin,
    input  R0out, R1out, PCout, MDRout, ZLOout,
    input  IncrementPC, Read, ALUControl, Mdatain,
    output big_boy_bus, R0_data_out, R1_data_out,
    output MDR_data_in, MDR_data_out, Y_data_out, Z_data_out
  );

  modport master (
    output R0in, R1in, PCin, MARin, MDRin, IRin, Yin, Zin,
    output R0out, R1out, PCout, MDRout, ZLOout,
    output IncrementPC, Read, ALUControl, Mdatain,
    input  big_boy_bus, R0_data_out, R1_data_out,
    input  MDR_data_in, MDR_data_out, Y_data_out, Z_data_out
  );

endinterface

// File: rtl/phase1_datapath_alu.sv
// Combinational ALU: operand A (Y register), operand B (bus), 64-bit result.
//   a_i, b_i : WIDTH-bit operands
//   op_i     : ALUControl opcode
//   result_o : ZW-bit result (zero-extended except MUL and DIV)
module phase1_alu
  import phase1_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  output logic [ZW-1:0]    result_o
);

  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SHW-1:0]           sh;
  logic [ZW-1:0]            dbl_r;
  logic [ZW-1:0]            dbl_l;
  logic [WIDTH-1:0]         sra;
  logic signed [ZW-1:0]     a_ext, b_ext, prod;
  logic signed [WIDTH-1:0]  quo, rem;

  // Shared intermediates: rotates via a doubled word, sign-extended product, guarded divide.
  always_comb begin
    sh    = b_i[SHW-1:0];
    dbl_r = {a_i, a_i} >> sh;
    dbl_l = {a_i, a_i} << sh;
    sra   = WIDTH'($signed(a_i) >>> sh);
    a_ext = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i});
    b_ext = $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    prod  = a_ext * b_ext;
    quo   = '0;
    rem   = '0;
    if (b_i == ZERO_W) begin
      quo = '0;
      rem = '0;
    end else if (a_i == INT_MIN && b_i == '1) begin
      // The one signed overflow case: quotient wraps to INT_MIN, remainder 0.
      quo = $signed(a_i);
      rem = '0;
    end else begin
      quo = $signed(a_i) / $signed(b_i);
      rem = $signed(a_i) % $signed(b_i);
    end
  end

  // Opcode select; unused encodings produce 0.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_INC:  result_o = {ZERO_W, b_i + WIDTH'(1)};
      OP_ADD:  result_o = {ZERO_W, a_i + b_i};
      OP_SUB:  result_o = {ZERO_W, a_i - b_i};
      OP_AND:  result_o = {ZERO_W, a_i & b_i};
      OP_OR:   result_o = {ZERO_W, a_i | b_i};
      OP_SHR:  result_o = {ZERO_W, a_i >> sh};
      OP_SHRA: result_o = {ZERO_W, sra};
      OP_SHL:  result_o = {ZERO_W, a_i << sh};
      OP_ROR:  result_o = {ZERO_W, dbl_r[WIDTH-1:0]};
      OP_ROL:  result_o = {ZERO_W, dbl_l[ZW-1:WIDTH]};
      OP_NEG:  result_o = {ZERO_W, ZERO_W - b_i};
      OP_NOT:  result_o = {ZERO_W, ~b_i};
      OP_MUL:  result_o = prod;
      OP_DIV:  result_o = {rem, quo};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/phase1_datapath.sv
// Phase-1 single-bus CPU datapath: R0, R1, PC, MAR, MDR, IR, Y, 64-bit Z,
// a priority bus mux and the ALU. All control comes from outside.
//   Clock : rising-edge clock
//   clear : asynchronous active-high reset of every register
//   dp    : strobes, memory read data and observation outputs
module phase1_datapath
  import phase1_pkg::*;
(
  input  logic              Clock,
  input  logic              clear,
  phase1_datapath_if.slave  dp
);

  logic [WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, pc_q, pc_d;
  logic [WIDTH-1:0] mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d, y_q, y_d;
  logic [ZW-1:0]    z_q, z_d;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] mdr_in;
  logic [ZW-1:0]    alu_res;
  logic             unused_regs;

  // Fixed-priority bus source: MDR > Z low > PC > R1 > R0, else 0.
  always_comb begin
    bus = '0;
    if (dp.MDRout)      bus = mdr_q;
    else if (dp.ZLOout) bus = z_q[WIDTH-1:0];
    else if (dp.PCout)  bus = pc_q;
    else if (dp.R1out)  bus = r1_q;
    else if (dp.R0out)  bus = r0_q;
  end

  assign mdr_in = dp.Read ? dp.Mdatain : bus;

  phase1_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus),
    .op_i     (dp.ALUControl),
    .result_o (alu_res)
  );

  // Next-state: load from bus on strobe, otherwise hold.
  always_comb begin
    r0_d  = dp.R0in  ? bus     : r0_q;
    r1_d  = dp.R1in  ? bus     : r1_q;
    mar_d = dp.MARin ? bus     : mar_q;
    ir_d  = dp.IRin  ? bus     : ir_q;
    y_d   = dp.Yin   ? bus     : y_q;
    mdr_d = dp.MDRin ? mdr_in  : mdr_q;
    z_d   = dp.Zin   ? alu_res : z_q;
    pc_d  = pc_q;
    if (dp.PCin) pc_d = dp.IncrementPC ? pc_q + WIDTH'(1) : bus;
  end

  // Register bank.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      r0_q  <= '0;
      r1_q  <= '0;
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      r0_q  <= r0_d;
      r1_q  <= r1_d;
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

  // MAR and IR have no consumers yet in phase 1.
  assign unused_regs = ^{mar_q, ir_q};

  assign dp.big_boy_bus  = bus;
  assign dp.R0_data_out  = r0_q;
  assign dp.R1_data_out  = r1_q;
  assign dp.MDR_data_in  = mdr_in;
  assign dp.MDR_data_out = mdr_q;
  assign dp.Y_data_out   = y_q;
  assign dp.Z_data_out   = z_q;

endmodule

// File: tb/tb_phase1_datapath.sv
// Self-checking bench for phase1_datapath: a table of micro-operations with
// hand-computed results, plus hand-written reset, fetch and PC sequences.
module tb_phase1_datapath;
  import phase1_pkg::*;

  localparam logic [14:0] C_R0IN  = 15'h0001;
  localparam logic [14:0] C_R1IN  = 15'h0002;
  localparam logic [14:0] C_PCIN  = 15'h0004;
  localparam logic [14:0] C_MARIN = 15'h0008;
  localparam logic [14:0] C_MDRIN = 15'h0010;
  localparam logic [14:0] C_IRIN  = 15'h0020;
  localparam logic [14:0] C_YIN   = 15'h0040;
  localparam logic [14:0] C_ZIN   = 15'h0080;
  localparam logic [14:0] C_R0OUT = 15'h0100;
  localparam logic [14:0] C_R1OUT = 15'h0200;
  localparam logic [14:0] C_PCOUT = 15'h0400;
  localparam logic [14:0] C_MDROUT= 15'h0800;
  localparam logic [14:0] C_ZLO   = 15'h1000;
  localparam logic [14:0] C_INCPC = 15'h2000;
  localparam logic [14:0] C_READ  = 15'h4000;
  localparam int NV = 22;

  typedef struct {
    logic [14:0] ctl;
    logic [4:0]  op;
    logic [31:0] md;
    logic [31:0] bus;
    logic [31:0] r0, r1, mdr, y;
    logic [63:0] z;
  } vec_t;

  logic Clock = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NV];

  phase1_datapath_if dp_if ();

  phase1_datapath dut (
    .Clock (Clock),
    .clear (clear),
    .dp    (dp_if.slave)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [14:0] ctl, input logic [4:0] op, input logic [31:0] md);
    dp_if.R0in        = ctl[0];
    dp_if.R1in        = ctl[1];
    dp_if.PCin        = ctl[2];
    dp_if.MARin       = ctl[3];
    dp_if.MDRin       = ctl[4];
    dp_if.IRin        = ctl[5];
    dp_if.Yin         = ctl[6];
    dp_if.Zin         = ctl[7];
    dp_if.R0out       = ctl[8];
    dp_if.R1out       = ctl[9];
    dp_if.PCout       = ctl[10];
    dp_if.MDRout      = ctl[11];
    dp_if.ZLOout      = ctl[12];
    dp_if.IncrementPC = ctl[13];
    dp_if.Read        = ctl[14];
    dp_if.ALUControl  = op;
    dp_if.Mdatain     = md;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"}, 64'(dp_if.big_boy_bus),  64'h0);
    chk({tag, "_r0"},  64'(dp_if.R0_data_out),  64'h0);
    chk({tag, "_r1"},  64'(dp_if.R1_data_out),  64'h0);
    chk({tag, "_mdr"}, 64'(dp_if.MDR_data_out), 64'h0);
    chk({tag, "_y"},   64'(dp_if.Y_data_out),   64'h0);
    chk({tag, "_z"},   dp_if.Z_data_out,        64'h0);
  endtask

  initial begin
    vecs[0]  = '{C_READ|C_MDRIN,  OP_INC, 32'h12, 32'h0,  32'h0, 32'h0, 32'h12, 32'h0, 64'h0};
    vecs[1]  = '{C_MDROUT|C_R1IN, OP_INC, 32'h0,  32'h12, 32'h0, 32'h12, 32'h12, 32'h0, 64'h0};
    vecs[2]  = '{C_READ|C_MDRIN,  OP_INC, 32'h14, 32'h0,  32'h0, 32'h12, 32'h14, 32'h0, 64'h0};
    vecs[3]  = '{C_MDROUT|C_R0IN, OP_INC, 32'h0,  32'h14, 32'h14, 32'h12, 32'h14, 32'h0, 64'h0};
    vecs[4]  = '{C_R1OUT|C_ZIN,   OP_NOT, 32'h0,  32'h12, 32'h14, 32'h12, 32'h14, 32'h0, 64'h00000000FFFFFFED};
    vecs[5]  = '{C_ZLO|C_R0IN,    OP_INC, 32'h0,  32'hFFFFFFED, 32'hFFFFFFED, 32'h12, 32'h14, 32'h0, 64'h00000000FFFFFFED};
    vecs[6]  = '{C_MDROUT|C_YIN,  OP_INC, 32'h0,  32'h14, 32'hFFFFFFED, 32'h12, 32'h14, 32'h14, 64'h00000000FFFFFFED};
    vecs[7]  = '{C_R1OUT|C_ZIN,   OP_ADD, 32'h0,  32'h12, 32'hFFFFFFED, 32'h12, 32'h14, 32'h14, 64'h26};
    vecs[8]  = '{C_R1OUT|C_ZIN,   OP_SUB, 32'h0,  32'h12, 32'hFFFFFFED, 32'h12, 32'h14, 32'h14, 64'h2};
    vecs[9]  = '{C_READ|C_MDRIN,  OP_INC, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFED, 32'h12, 32'hFFFFFFFF, 32'h14, 64'h2};
    vecs[10] = '{C_MDROUT|C_YIN,  OP_INC, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFED, 32'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h2};
    vecs[11] = '{C_ZLO|C_ZIN,     OP_MUL, 32'h0,  32'h2,  32'hFFFFFFED, 32'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE};
    vecs[12] = '{C_READ|C_MDRIN,  OP_INC, 32'h14, 32'h0,  32'hFFFFFFED, 32'h12, 32'h14, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE};
    vecs[13] = '{C_MDROUT|C_YIN,  OP_INC, 32'h0,  32'h14, 32'hFFFFFFED, 32'h12, 32'h14, 32'h14, 64'hFFFFFFFFFFFFFFFE};
    vecs[14] = '{C_READ|C_MDRIN,  OP_INC, 32'h3,  32'h0,  32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'hFFFFFFFFFFFFFFFE};
    vecs[15] = '{C_MDROUT|C_ZIN,  OP_DIV, 32'h0,  32'h3,  32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h0000000200000006};
    vecs[16] = '{C_MDROUT|C_R0OUT,OP_INC, 32'h0,  32'h3,  32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h0000000200000006};
    vecs[17] = '{15'h0,           OP_INC, 32'h0,  32'h0,  32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h0000000200000006};
    vecs[18] = '{C_R1OUT|C_R1IN,  OP_INC, 32'h0,  32'h12, 32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h0000000200000006};
    vecs[19] = '{C_R1OUT|C_ZIN,   5'b11111, 32'h0, 32'h12, 32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h0};
    vecs[20] = '{C_R1OUT|C_ZIN,   OP_INC, 32'h0,  32'h12, 32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h13};
    vecs[21] = '{C_ZIN,           OP_DIV, 32'h0,  32'h0,  32'hFFFFFFED, 32'h12, 32'h3, 32'h14, 64'h0};

    // Power-on reset.
    clear = 1'b1;
    drive(15'h0, OP_INC, 32'h0);
    tick();
    tick();
    chk_all_zero("rst");
    clear = 1'b0;
    tick();
    chk_all_zero("rst_rel");

    // Table of micro-operations.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ctl, vecs[i].op, vecs[i].md);
      #1;
      chk($sformatf("v%0d_bus", i), 64'(dp_if.big_boy_bus), 64'(vecs[i].bus));
      tick();
      chk($sformatf("v%0d_r0", i),  64'(dp_if.R0_data_out),  64'(vecs[i].r0));
      chk($sformatf("v%0d_r1", i),  64'(dp_if.R1_data_out),  64'(vecs[i].r1));
      chk($sformatf("v%0d_mdr", i), 64'(dp_if.MDR_data_out), 64'(vecs[i].mdr));
      chk($sformatf("v%0d_y", i),   64'(dp_if.Y_data_out),   64'(vecs[i].y));
      chk($sformatf("v%0d_z", i),   dp_if.Z_data_out,        vecs[i].z);
    end

    // MDR input mux follows Read combinationally.
    drive(C_READ|C_R1OUT, OP_INC, 32'hA5A5_0001);
    #1;
    chk("mdrin_read", 64'(dp_if.MDR_data_in), 64'hA5A50001);
    drive(C_R1OUT, OP_INC, 32'hA5A5_0001);
    #1;
    chk("mdrin_bus", 64'(dp_if.MDR_data_in), 64'h12);

    // Mid-cycle clear: immediate zero, and overrides load strobes across an edge.
    drive(C_R1OUT|C_R0IN|C_YIN|C_ZIN|C_READ|C_MDRIN, OP_INC, 32'h55);
    #2;
    clear = 1'b1;
    #1;
    chk_all_zero("clr_now");
    tick();
    chk_all_zero("clr_edge");
    drive(15'h0, OP_INC, 32'h0);
    #2;
    clear = 1'b0;
    tick();
    chk_all_zero("clr_rel");

    // Fetch from reset.
    drive(C_PCOUT|C_MARIN|C_ZIN, OP_INC, 32'h0);
    #1;
    chk("f1_bus", 64'(dp_if.big_boy_bus), 64'h0);
    tick();
    chk("f1_z", dp_if.Z_data_out, 64'h1);
    drive(C_ZLO|C_PCIN|C_INCPC|C_READ|C_MDRIN, OP_INC, 32'h28918000);
    tick();
    chk("f2_mdr", 64'(dp_if.MDR_data_out), 64'h28918000);
    drive(C_MDROUT|C_IRIN, OP_INC, 32'h0);
    #1;
    chk("f3_bus", 64'(dp_if.big_boy_bus), 64'h28918000);
    tick();
    drive(C_PCOUT, OP_INC, 32'h0);
    #1;
    chk("f_pc", 64'(dp_if.big_boy_bus), 64'h1);

    // PC load from bus, IncrementPC alone, and increment wrap.
    drive(C_READ|C_MDRIN, OP_INC, 32'hFFFFFFFF);
    tick();
    drive(C_MDROUT|C_PCIN, OP_INC, 32'h0);
    tick();
    drive(C_PCOUT, OP_INC, 32'h0);
    #1;
    chk("pc_load", 64'(dp_if.big_boy_bus), 64'hFFFFFFFF);
    drive(C_INCPC, OP_INC, 32'h0);
    tick();
    drive(C_PCOUT, OP_INC, 32'h0);
    #1;
    chk("pc_incalone", 64'(dp_if.big_boy_bus), 64'hFFFFFFFF);
    drive(C_MDROUT|C_PCIN|C_INCPC, OP_INC, 32'h0);
    tick();
    drive(C_PCOUT, OP_INC, 32'h0);
    #1;
    chk("pc_wrap", 64'(dp_if.big_boy_bus), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
